apb_interconnect_n: RTL and testbench
=====================================

Name: apb_interconnect_n

Overview:
- Parametrised APB bridge and interconnect: successor to the fixed six-slave APB interconnect.
- Accepts single transfers from a simple valid/ready master port and decodes the slave from the upper address bits.
- Drives a full APB SETUP/ACCESS sequence to one of NUM_SLAVES slaves, then returns read data and error status to the master.
- Adds per-slave PREADY wait states, PSLVERR propagation, an unmapped-address error and an ACCESS timeout.

Parameters:
- NUM_SLAVES, 6: number of APB slaves, 1..16.
- ADDR_WIDTH, 12: address width, ≥ 5.
- DATA_WIDTH, 32: data width.
- TIMEOUT, 16: maximum ACCESS cycles before abort, ≥ 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  1  master request valid.
- req_ready  out  1  request accepted when high together with req_valid.
- req_addr  in  ADDR_WIDTH  transfer address.
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  DATA_WIDTH  write data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- resp_err  out  1  error flag, valid with resp_valid.
- paddr  out  ADDR_WIDTH  APB address.
- pwrite  out  1  APB write.
- pwdata  out  DATA_WIDTH  APB write data.
- penable  out  1  APB enable.
- psel  out  NUM_SLAVES  one-hot slave select.
- prdata  in  NUM_SLAVES*DATA_WIDTH  slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- pready  in  NUM_SLAVES  per-slave ready.
- pslverr  in  NUM_SLAVES  per-slave error.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; timeout counter cleared.
  - All outputs go to 0, except req_ready, which is 1 once in IDLE.
  - Reset mid-transfer aborts the transfer with no response and drops psel/penable immediately.
- Decode: idx = req_addr[ADDR_WIDTH-1:ADDR_WIDTH-4]. The slave is mapped iff idx < NUM_SLAVES.
- State IDLE:
  - req_ready = 1.
  - On an edge with req_valid=1: latch addr/write/wdata into paddr/pwrite/pwdata and latch idx.
  - Mapped address: go to SETUP.
  - Unmapped address: go to ERR.
- State SETUP (1 cycle):
  - psel[idx]=1, penable=0, req_ready=0.
  - Next edge goes to ACCESS.
- State ACCESS:
  - psel[idx]=1, penable=1. The counter increments every cycle, starting at 1 on entry.
  - Edge with pready[idx]=1: resp_valid<=1; resp_err<=pslverr[idx]; resp_rdata<=prdata slice idx if read, else 0.
  - The same edge clears psel/penable and returns to IDLE.
  - Edge with pready[idx]=0 and counter==TIMEOUT: resp_valid<=1, resp_err<=1, resp_rdata<=0, go to IDLE.
  - pready and pslverr of unselected slaves are ignored.
- State ERR (1 cycle):
  - No psel asserted.
  - Next edge: resp_valid<=1, resp_err<=1, resp_rdata<=0, go to IDLE.
- Response timing:
  - resp_valid is high for exactly one cycle, the first IDLE cycle after completion.
  - resp_rdata/resp_err hold their value until the next completion.
  - A new request may be accepted in that same cycle (back-to-back).
- paddr/pwrite/pwdata:
  - Stable from SETUP through the end of ACCESS.
  - Hold their last value in IDLE; they change only on acceptance.
- Latency, accept edge to resp_valid:
  - Zero-wait slave: 3 cycles.
  - Each wait state adds 1 cycle.
  - Timeout: TIMEOUT+2 cycles.
  - Unmapped address: 2 cycles.
- Not supported: PPROT/PSTRB, and more than one outstanding request.

Test Plan:
- Write 0x300, data 13, slave 3 pready tied 1 → psel=6'b001000 SETUP 1 cycle then penable 1 cycle; resp_valid 3 cycles after accept, resp_err=0, resp_rdata=0.
- Read 0x500, slave 5 prdata=0xDEADBEEF, pready low 2 cycles → ACCESS lasts 3 cycles; resp_rdata=0xDEADBEEF, latency 5.
- Read 0x000 with pslverr[0]=1 at pready → resp_err=1; psel[0] only; other slaves' pready toggling has no effect.
- Access 0x700 (idx 7 ≥ 6) → no psel ever; resp_valid+resp_err 2 cycles after accept; next request accepted the following cycle.
- Slave 4 pready held 0, TIMEOUT=16 → penable high 16 cycles, then resp_err=1, psel cleared, req_ready=1.
- Assert rst=0 mid-ACCESS of a write to 0x200 → psel/penable/resp_valid 0 immediately; no response after release; next write to 0x100 completes normally.

Source files
------------

// File: rtl/apb_interconnect_n.sv
// APB bridge and interconnect: one valid/ready master port to NUM_SLAVES APB slaves.
// The slave is decoded from the top four address bits. Adds wait states, PSLVERR, unmapped-address errors and an ACCESS timeout.
module apb_interconnect_n #(
    parameter int NUM_SLAVES = 6,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic                             req_write,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    output logic                             resp_valid,
    output logic [DATA_WIDTH-1:0]            resp_rdata,
    output logic                             resp_err,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic                             pwrite,
    output logic [DATA_WIDTH-1:0]            pwdata,
    output logic                             penable,
    output logic [NUM_SLAVES-1:0]            psel,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]            pready,
    input  logic [NUM_SLAVES-1:0]            pslverr
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [3:0]              idx;
    logic                    mapped;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;

    assign idx       = req_addr[ADDR_WIDTH-1:ADDR_WIDTH-4];
    assign mapped    = ({1'b0, idx} < 5'(NUM_SLAVES));
    assign req_ready = (state == IDLE);

    // psel holds the latched one-hot slave index, so it selects the slave's response directly.
    always_comb begin
        sel_ready = |(pready & psel);
        sel_err   = |(pslverr & psel);
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (psel[i]) sel_rdata = sel_rdata | prdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            penable    <= 1'b0;
            psel       <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        paddr  <= req_addr;
                        pwrite <= req_write;
                        pwdata <= req_wdata;
                        if (mapped) begin
                            psel  <= NUM_SLAVES'(1) << idx;
                            state <= SETUP;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    cnt     <= CW'(1);
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // A ready slave wins over the timeout on the same edge.
                    if (sel_ready) begin
                        resp_valid <= 1'b1;
                        resp_err   <= sel_err;
                        resp_rdata <= pwrite ? '0 : sel_rdata;
                        psel       <= '0;
                        penable    <= 1'b0;
                        state      <= IDLE;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        psel       <= '0;
                        penable    <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ERR: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                    resp_rdata <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_interconnect_n.sv
// Randomized self-checking bench for apb_interconnect_n.
// Expected responses come from a transaction-level model of decode, latency and error rules.
module tb_apb_interconnect_n;

    localparam int NS = 6;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [AW-1:0]     req_addr;
    logic              req_write;
    logic [DW-1:0]     req_wdata;
    logic              resp_valid;
    logic [DW-1:0]     resp_rdata;
    logic              resp_err;
    logic [AW-1:0]     paddr;
    logic              pwrite;
    logic [DW-1:0]     pwdata;
    logic              penable;
    logic [NS-1:0]     psel;
    logic [NS*DW-1:0]  prdata;
    logic [NS-1:0]     pready;
    logic [NS-1:0]     pslverr;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] last_rd;
    logic          last_err;

    apb_interconnect_n #(
        .NUM_SLAVES(NS),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .penable(penable),
        .psel(psel), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Unselected slaves present random noise that must be ignored.
    task automatic scramble();
        pready  = NS'($urandom);
        pslverr = NS'($urandom);
        for (int i = 0; i < NS; i++) prdata[i*DW +: DW] = $urandom;
    endtask

    // Starts at a negedge in IDLE, returns at the negedge where resp_valid is high.
    task automatic do_txn(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                          input int waits, input logic serr, input logic [DW-1:0] rd);
        int            idx;
        bit            mapped;
        int            acc;
        int            last_k;
        logic [NS-1:0] oh;
        logic          exp_err;
        logic [DW-1:0] exp_rd;

        idx    = int'(addr >> (AW - 4));
        mapped = (idx < NS);
        acc    = (waits >= TO) ? TO : waits + 1;
        oh     = mapped ? (NS'(1) << idx) : '0;
        last_k = mapped ? acc + 1 : 1;
        if (!mapped || waits >= TO) begin
            exp_err = 1'b1;
            exp_rd  = '0;
        end else begin
            exp_err = serr;
            exp_rd  = wr ? '0 : rd;
        end

        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = wr;
        req_wdata = wd;
        scramble();
        for (int k = 0; k <= last_k; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 1'b0;
            check("psel", psel, (mapped && k <= acc) ? oh : '0);
            check("penable", penable, (mapped && k >= 1 && k <= acc) ? 1 : 0);
            check("resp_valid", resp_valid, (k == last_k) ? 1 : 0);
            check("req_ready", req_ready, (k == last_k) ? 1 : 0);
            if (k == 0 || k == last_k) begin
                check("paddr", paddr, addr);
                check("pwrite", pwrite, wr);
                check("pwdata", pwdata, wd);
            end
            if (k == last_k) begin
                check("resp_err", resp_err, exp_err);
                check("resp_rdata", resp_rdata, exp_rd);
            end
            scramble();
            if (mapped) begin
                pready[idx]           = (k > waits);
                pslverr[idx]          = serr;
                prdata[idx*DW +: DW]  = rd;
            end
        end
        last_rd  = exp_rd;
        last_err = exp_err;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check("idle_resp_valid", resp_valid, 0);
        check("hold_rdata", resp_rdata, last_rd);
        check("hold_err", resp_err, last_err);
    endtask

    initial begin
        logic [AW-1:0] a;
        int            w;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        pready    = '0;
        pslverr   = '0;
        prdata    = '0;
        #12;
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_paddr", paddr, 0);
        check("rst_req_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_txn(12'h300, 1'b1, 32'd13, 0, 1'b0, 32'h1234_5678);
        idle_cycle();
        do_txn(12'h500, 1'b0, 32'h0, 2, 1'b0, 32'hDEAD_BEEF);
        idle_cycle();
        do_txn(12'h000, 1'b0, 32'h0, 1, 1'b1, 32'h0BAD_F00D);
        idle_cycle();
        do_txn(12'h700, 1'b0, 32'h0, 0, 1'b0, 32'h5555_AAAA);
        do_txn(12'h1A4, 1'b0, 32'h0, 0, 1'b0, 32'hCAFE_0001);
        idle_cycle();
        do_txn(12'h400, 1'b1, 32'h77, TO, 1'b0, 32'h0);
        idle_cycle();
        do_txn(12'h2F0, 1'b0, 32'h0, TO - 1, 1'b0, 32'hA5A5_5A5A);
        idle_cycle();

        // Reset in the middle of ACCESS.
        req_valid = 1'b1;
        req_addr  = 12'h200;
        req_write = 1'b1;
        req_wdata = 32'hFEED;
        pready    = '0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_penable", penable, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_psel", psel, 0);
        check("mid_rst_penable", penable, 0);
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_req_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_resp", resp_valid, 0);
            check("post_rst_psel", psel, 0);
        end
        do_txn(12'h100, 1'b1, 32'h42, 0, 1'b0, 32'h0);
        idle_cycle();

        for (int n = 0; n < 60; n++) begin
            a = AW'($urandom);
            w = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? TO : TO - 1)
                                            : int'($urandom_range(0, 4));
            do_txn(a, 1'($urandom), $urandom, w, 1'($urandom), $urandom);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
